// File: rtl/chroni_pixel_expander_if.sv
// chroni_pixel_expander_if: pixel request handshake and line buffer write bundle
interface chroni_pixel_expander_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int CNT_W = $clog2(DATA_W) + 1
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic [1:0] in_mode;
  logic [CNT_W-1:0] in_count;
  logic [3:0] in_palette;
  logic [7:0] in_on;
  logic [7:0] in_off;
  logic in_scale;
  logic in_transparent;
  logic lb_wr_en;
  logic [ADDR_W-1:0] lb_wr_addr;
  logic [7:0] lb_wr_data;
  logic busy;
  modport master (
    output in_valid, in_data, in_addr, in_mode, in_count, in_palette, in_on, in_off, in_scale, in_transparent,
    input in_ready, lb_wr_en, lb_wr_addr, lb_wr_data, busy
  );
  modport slave (
    input in_valid, in_data, in_addr, in_mode, in_count, in_palette, in_on, in_off, in_scale, in_transparent,
    output in_ready, lb_wr_en, lb_wr_addr, lb_wr_data, busy
  );
endinterface

// File: rtl/chroni_pixel_expander.sv
// chroni_pixel_expander: unpacks packed pixel words into line buffer writes
module chroni_pixel_expander #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int LINE_LEN = 1280,
  parameter int CNT_W = $clog2(DATA_W) + 1
) (
  input logic clk,
  input logic reset,
  chroni_pixel_expander_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;
  localparam logic [ADDR_W:0] LL = (ADDR_W + 1)'(LINE_LEN);
  state_t st;
  logic [DATA_W-1:0] d, cd, sh;
  logic [1:0] m, cm;
  logic [3:0] pal, cpal;
  logic [7:0] on, off, con, coff, px;
  logic sc, tr, ctr, r, nr, last, acc, z, en;
  logic [CNT_W-1:0] n, p, cn, np, mx, sa;
  logic [ADDR_W-1:0] na;
  assign last = p == n - 1'b1 && (!sc || r);
  assign bus.in_ready = !reset && (st == IDLE || last);
  assign bus.busy = st == EMIT;
  assign acc = bus.in_valid && bus.in_ready;
  // next slot: taken from the incoming request on acceptance, else from the held request
  always_comb begin
    cd = acc ? bus.in_data : d;
    cm = acc ? bus.in_mode : m;
    cpal = acc ? bus.in_palette : pal;
    con = acc ? bus.in_on : on;
    coff = acc ? bus.in_off : off;
    ctr = acc ? bus.in_transparent : tr;
    mx = cm == 2'd1 ? CNT_W'(DATA_W) : cm == 2'd2 ? CNT_W'(DATA_W / 2) : CNT_W'(DATA_W / 4);
    cn = !acc ? n : cm == 2'd0 ? CNT_W'(1) : bus.in_count > mx ? mx : bus.in_count;
    nr = !acc && sc && !r;
    np = acc ? '0 : nr ? p : p + 1'b1;
    na = acc ? bus.in_addr : bus.lb_wr_addr + 1'b1;
    sa = cm == 2'd1 ? cn - 1'b1 - np : cm == 2'd2 ? np << 1 : np << 2;
    sh = cd >> sa;
    px = cm == 2'd0 ? cd[7:0] : cm == 2'd1 ? (sh[0] ? con : coff) : cm == 2'd2 ? {cpal, 2'b00, sh[1:0]} : {cpal, sh[3:0]};
    z = cm == 2'd0 ? cd[7:0] == 8'd0 : cm == 2'd1 ? !sh[0] : cm == 2'd2 ? sh[1:0] == 2'd0 : sh[3:0] == 4'd0;
    en = !(ctr && z) && {1'b0, na} < LL;
  end
  // request capture, slot sequencing and registered line buffer write port
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      bus.lb_wr_en <= 1'b0;
      bus.lb_wr_addr <= '0;
      bus.lb_wr_data <= '0;
      d <= '0;
      m <= '0;
      pal <= '0;
      on <= '0;
      off <= '0;
      sc <= 1'b0;
      tr <= 1'b0;
      n <= '0;
      p <= '0;
      r <= 1'b0;
    end else begin
      if (acc) begin
        d <= bus.in_data;
        m <= bus.in_mode;
        pal <= bus.in_palette;
        on <= bus.in_on;
        off <= bus.in_off;
        sc <= bus.in_scale;
        tr <= bus.in_transparent;
      end
      n <= cn;
      p <= np;
      r <= nr;
      if (acc ? cn != '0 : st == EMIT && !last) begin
        st <= EMIT;
        bus.lb_wr_en <= en;
        bus.lb_wr_addr <= na;
        bus.lb_wr_data <= px;
      end else begin
        st <= IDLE;
        bus.lb_wr_en <= 1'b0;
      end
    end
endmodule

// File: tb/tb_chroni_pixel_expander.sv
// tb_chroni_pixel_expander: random and directed requests against a slot-list reference model
module tb_chroni_pixel_expander;
  typedef struct packed {
    logic v;
    logic [15:0] data;
    logic [10:0] addr;
    logic [1:0] mode;
    logic [4:0] cnt;
    logic [3:0] pal;
    logic [7:0] on, off;
    logic sc, tr;
  } req_t;
  typedef struct packed {
    logic en;
    logic [10:0] addr;
    logic [7:0] data;
  } slot_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  chroni_pixel_expander_if bus();
  chroni_pixel_expander dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  slot_t q[$];
  int n_chk = 0;
  int n_err = 0;
  logic acc;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic req_t mk(int mode, int data, int addr, int cnt, int pal, int on, int off, int sc, int tr);
    req_t r;
    r.v = 1'b1;
    r.mode = 2'(mode);
    r.data = 16'(data);
    r.addr = 11'(addr);
    r.cnt = 5'(cnt);
    r.pal = 4'(pal);
    r.on = 8'(on);
    r.off = 8'(off);
    r.sc = 1'(sc);
    r.tr = 1'(tr);
    return r;
  endfunction
  function automatic req_t rnd();
    int sel;
    int a;
    sel = $urandom_range(0, 7);
    a = sel < 2 ? $urandom_range(1272, 1290) : sel == 2 ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
    rnd = mk($urandom_range(0, 3), $urandom, a, $urandom_range(0, 18), $urandom, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
    rnd.v = $urandom_range(0, 9) < 6;
  endfunction
  // expands one accepted request into its list of write slots, appended after the slots still pending
  function automatic void model(req_t r);
    int bpp, n, idx, col, si, a;
    slot_t s;
    bpp = r.mode == 1 ? 1 : r.mode == 2 ? 2 : 4;
    n = r.mode == 0 ? 1 : (r.cnt > 16 / bpp ? 16 / bpp : int'(r.cnt));
    si = 0;
    for (int k = 0; k < n; k++) begin
      if (r.mode == 0) begin
        idx = int'(r.data[7:0]);
        col = idx;
      end else if (r.mode == 1) begin
        idx = (int'(r.data) >> (n - 1 - k)) % 2;
        col = idx != 0 ? int'(r.on) : int'(r.off);
      end else begin
        idx = (int'(r.data) >> (bpp * k)) % (1 << bpp);
        col = int'(r.pal) * 16 + idx;
      end
      for (int j = 0; j < (r.sc ? 2 : 1); j++) begin
        a = (int'(r.addr) + si) % 2048;
        s.en = !(r.tr && idx == 0) && a < 1280;
        s.addr = 11'(a);
        s.data = 8'(col);
        q.push_back(s);
        si++;
      end
    end
  endfunction
  task automatic drive(req_t r);
    bus.in_valid = r.v;
    bus.in_data = r.data;
    bus.in_addr = r.addr;
    bus.in_mode = r.mode;
    bus.in_count = r.cnt;
    bus.in_palette = r.pal;
    bus.in_on = r.on;
    bus.in_off = r.off;
    bus.in_scale = r.sc;
    bus.in_transparent = r.tr;
  endtask
  task automatic step(req_t r);
    slot_t c;
    @(negedge clk);
    c = q.size() != 0 ? q[0] : '0;
    check("wr_en", 32'(bus.lb_wr_en), 32'(c.en));
    if (c.en) begin
      check("wr_addr", 32'(bus.lb_wr_addr), 32'(c.addr));
      check("wr_data", 32'(bus.lb_wr_data), 32'(c.data));
    end
    check("busy", 32'(bus.busy), 32'(q.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(q.size() <= 1));
    drive(r);
    acc = r.v && q.size() <= 1;
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (acc) model(r);
  endtask
  task automatic send(req_t r);
    for (int i = 0; i < 64; i++) begin
      step(r);
      if (acc) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle(int k);
    for (int i = 0; i < k; i++) step('0);
  endtask
  task automatic check_reset_state();
    check("rst_wr_en", 32'(bus.lb_wr_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", 32'(bus.lb_wr_addr), 32'd0);
    check("rst_data", 32'(bus.lb_wr_data), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
  endtask
  initial begin
    drive('0);
    #1 check_reset_state();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    send(mk(1, 16'h00A5, 10, 8, 0, 8'hF0, 8'h0F, 0, 0));
    idle(10);
    send(mk(3, 16'h3210, 20, 4, 5, 0, 0, 0, 1));
    idle(6);
    send(mk(2, 16'h001B, 100, 2, 2, 0, 0, 1, 0));
    idle(6);
    send(mk(3, 16'h3210, 1278, 4, 1, 0, 0, 0, 0));
    idle(6);
    send(mk(3, 16'h7654, 200, 4, 3, 0, 0, 0, 0));
    send(mk(3, 16'hBA98, 204, 4, 4, 0, 0, 0, 0));
    idle(10);
    send(mk(2, 16'hFFFF, 300, 0, 1, 0, 0, 0, 0));
    idle(3);
    send(mk(0, 16'h1234, 2047, 9, 0, 0, 0, 1, 0));
    idle(4);
    send(mk(1, 16'h00C3, 400, 8, 0, 8'hAA, 8'h55, 0, 0));
    idle(2);
    @(negedge clk) reset = 1'b1;
    #1 check_reset_state();
    q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_wr_en", 32'(bus.lb_wr_en), 32'd0);
      check("rst_hold_busy", 32'(bus.busy), 32'd0);
    end
    @(negedge clk) reset = 1'b0;
    send(mk(3, 16'hCDEF, 500, 4, 6, 0, 0, 1, 1));
    idle(10);
    repeat (1500) step(rnd());
    idle(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
